// File: rtl/alu_seq_pkg.sv
// ---------------------------------------------------------------------------
// alu_seq_pkg
// Shared definitions for the multi-cycle Polaris ALU (alu_seq):
//   - opcode values OP_ADD..OP_MUL (compared against int'(op))
//   - FSM state encoding IDLE/SHIFT/MUL/DONE
//   - shifter datapath mode encoding
//   - clog2() for the shift-amount and counter widths
// Optional feature macro used by the files that import this package:
//   ALU_SEQ_MUL_EN -- builds the shift-add multiplier for opcode 10.
// ---------------------------------------------------------------------------
package alu_seq_pkg;

  // Opcodes
  localparam int OP_ADD  = 0;
  localparam int OP_SUB  = 1;
  localparam int OP_SLL  = 2;
  localparam int OP_SLT  = 3;
  localparam int OP_SLTU = 4;
  localparam int OP_XOR  = 5;
  localparam int OP_SRL  = 6;
  localparam int OP_SRA  = 7;
  localparam int OP_OR   = 8;
  localparam int OP_AND  = 9;
  localparam int OP_MUL  = 10;

  // FSM state encoding (IDLE and DONE both accept requests)
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] MUL   = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  // Sequential datapath modes
  localparam logic [1:0] MODE_SLL = 2'd0;
  localparam logic [1:0] MODE_SRL = 2'd1;
  localparam logic [1:0] MODE_SRA = 2'd2;
  localparam logic [1:0] MODE_MUL = 2'd3;

  // Ceiling log2; clog2(1) = 0.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/alu_seq_shifter.sv
// ---------------------------------------------------------------------------
// alu_seq_shifter
// Sequential shift datapath of alu_seq. Holds the accumulator, the
// remaining-count register and the shift mode. Each step moves the
// accumulator by min(SHIFT_STEP, remaining) bits and reduces the count by
// the same amount. With ALU_SEQ_MUL_EN defined, MODE_MUL turns a step into
// "accumulator += add_i" with a count decrement of one, so the multiplier
// reuses the same accumulator and counter.
//
// Ports:
//   clk_i    in   clock
//   reset_i  in   asynchronous active-low reset
//   load_i   in   load accumulator, count and mode (has priority over step)
//   step_i   in   perform one step
//   mode_i   in   mode to load (MODE_SLL/SRL/SRA/MUL)
//   data_i   in   accumulator load value
//   cnt_i    in   count load value
//   add_i    in   addend for MODE_MUL (only with ALU_SEQ_MUL_EN)
//   step_o   out  accumulator value after the step in progress
//   zero_o   out  the step in progress brings the remaining count to zero
// ---------------------------------------------------------------------------
module alu_seq_shifter
  import alu_seq_pkg::*;
#(
  parameter int XLEN       = 64,
  parameter int SHIFT_STEP = 1,
  parameter int CW         = clog2(XLEN) + 1
) (
  input  logic            clk_i,
  input  logic            reset_i,
  input  logic            load_i,
  input  logic            step_i,
  input  logic [1:0]      mode_i,
  input  logic [XLEN-1:0] data_i,
  input  logic [CW-1:0]   cnt_i,
`ifdef ALU_SEQ_MUL_EN
  input  logic [XLEN-1:0] add_i,
`endif
  output logic [XLEN-1:0] step_o,
  output logic            zero_o
);

  localparam logic [CW-1:0] STEP_CW = CW'(SHIFT_STEP);

  logic [XLEN-1:0] acc_q;
  logic [CW-1:0]   rem_q;
  logic [CW-1:0]   amt;
  logic [1:0]      mode_q;

  // NOTE: every always_comb output gets a default first, so no path through
  // the case statement can leave it unassigned and infer a latch.
  always_comb begin
    amt    = (rem_q > STEP_CW) ? STEP_CW : rem_q;
    step_o = acc_q;
    case (mode_q)
      MODE_SLL: step_o = acc_q << amt;
      MODE_SRL: step_o = acc_q >> amt;
      MODE_SRA: step_o = $signed(acc_q) >>> amt;
`ifdef ALU_SEQ_MUL_EN
      MODE_MUL: begin
        amt    = CW'(1);
        step_o = acc_q + add_i;
      end
`endif
      default: ;
    endcase
  end

  // amt never exceeds rem_q, so equality means this step finishes.
  assign zero_o = (rem_q == amt);

  // NOTE: state is updated with non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      acc_q  <= '0;
      rem_q  <= '0;
      mode_q <= MODE_SLL;
    end else if (load_i) begin
      acc_q  <= data_i;
      rem_q  <= cnt_i;
      mode_q <= mode_i;
    end else if (step_i) begin
      acc_q  <= step_o;
      rem_q  <= rem_q - amt;
    end
  end

endmodule

// File: rtl/alu_seq.sv
// ---------------------------------------------------------------------------
// alu_seq
// Multi-cycle integer ALU for the Polaris pipeline. A request is accepted on
// a rising edge with valid_i && ready_o; done_o pulses for the cycle that
// follows edge accept+L, with result_o registered on that edge and held
// until the next done_o.
//   L = 1 for add/sub/compare/logic/undefined ops and for shifts with
//         s <= SHIFT_STEP (these run one result per clock back-to-back);
//   L = ceil(s/SHIFT_STEP) for longer shifts (state SHIFT, ready_o low);
//   L = XLEN for MUL when built (state MUL, ready_o low).
// Optional feature macro: ALU_SEQ_MUL_EN -- builds the radix-2 shift-add
// multiplier for opcode 10; without it opcode 10 returns 0 with L = 1.
//
// Ports:
//   clk_i     in   clock, rising edge
//   reset_i   in   asynchronous active-low reset
//   valid_i   in   request valid
//   ready_o   out  able to accept a request
//   op_i      in   opcode (OPW bits)
//   a_i       in   operand A
//   b_i       in   operand B; low log2(XLEN) bits are the shift amount
//   result_o  out  result, valid while done_o is high
//   done_o    out  one-cycle completion pulse
// ---------------------------------------------------------------------------
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int XLEN       = 64,
  parameter int SHIFT_STEP = 1,
  parameter int OPW        = 4
) (
  input  logic            clk_i,
  input  logic            reset_i,
  input  logic            valid_i,
  output logic            ready_o,
  input  logic [OPW-1:0]  op_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  output logic [XLEN-1:0] result_o,
  output logic            done_o
);

  localparam int SW = clog2(XLEN);
  localparam int CW = SW + 1;

  logic [1:0]      state_q, state_n;
  logic            pend_q, pend_n;
  logic [OPW-1:0]  op_q;
  logic [XLEN-1:0] a_q, b_q;
  logic [XLEN-1:0] result_n;
  logic            done_n;

  logic            accept;
  logic            is_shift_in;
  logic            long_shift_in;
  logic [SW-1:0]   shamt_in;
  logic [1:0]      mode_in;
  logic            sh_load, sh_step, sh_zero;
  logic [CW-1:0]   sh_cnt;
  logic [XLEN-1:0] sh_data, sh_out;
  logic [XLEN-1:0] alu_1c;

  assign ready_o = (state_q == IDLE) || (state_q == DONE);
  assign accept  = valid_i && ready_o;

  // ---------------- request decode ----------------
  assign shamt_in      = b_i[SW-1:0];
  assign is_shift_in   = (int'(op_i) == OP_SLL) || (int'(op_i) == OP_SRL) ||
                         (int'(op_i) == OP_SRA);
  assign long_shift_in = is_shift_in && (int'(shamt_in) > SHIFT_STEP);

  always_comb begin
    mode_in = MODE_SLL;
    case (int'(op_i))
      OP_SRL:  mode_in = MODE_SRL;
      OP_SRA:  mode_in = MODE_SRA;
      default: mode_in = MODE_SLL;
    endcase
  end

`ifdef ALU_SEQ_MUL_EN
  logic            is_mul_in;
  logic [XLEN-1:0] mcand_q, mplr_q, mul_add;

  assign is_mul_in = (int'(op_i) == OP_MUL);
  assign mul_add   = mplr_q[0] ? mcand_q : '0;
  assign sh_load   = accept && (is_shift_in || is_mul_in);
  assign sh_data   = is_mul_in ? '0 : a_i;
  assign sh_cnt    = is_mul_in ? CW'(XLEN) : {1'b0, shamt_in};
  assign sh_step   = (state_q == SHIFT) || (state_q == MUL);

  // Multiplicand walks left, multiplier walks right: one partial product
  // per MUL cycle is added into the shared accumulator.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      mcand_q <= '0;
      mplr_q  <= '0;
    end else if (accept && is_mul_in) begin
      mcand_q <= a_i;
      mplr_q  <= b_i;
    end else if (state_q == MUL) begin
      mcand_q <= mcand_q << 1;
      mplr_q  <= mplr_q >> 1;
    end
  end
`else
  assign sh_load = accept && is_shift_in;
  assign sh_data = a_i;
  assign sh_cnt  = {1'b0, shamt_in};
  assign sh_step = (state_q == SHIFT);
`endif

  alu_seq_shifter #(
    .XLEN       (XLEN),
    .SHIFT_STEP (SHIFT_STEP),
    .CW         (CW)
  ) u_shifter (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .load_i  (sh_load),
    .step_i  (sh_step),
    .mode_i  (
`ifdef ALU_SEQ_MUL_EN
              is_mul_in ? MODE_MUL :
`endif
              mode_in),
    .data_i  (sh_data),
    .cnt_i   (sh_cnt),
`ifdef ALU_SEQ_MUL_EN
    .add_i   (mul_add),
`endif
    .step_o  (sh_out),
    .zero_o  (sh_zero)
  );

  // ---------------- single-cycle ops on the captured request ----------------
  // Short shifts were loaded into the shifter on accept; their result is the
  // single step the shifter would take next.
  always_comb begin
    alu_1c = '0;
    case (int'(op_q))
      OP_ADD:  alu_1c = a_q + b_q;
      OP_SUB:  alu_1c = a_q - b_q;
      OP_SLT:  alu_1c = {{(XLEN-1){1'b0}}, ($signed(a_q) < $signed(b_q))};
      OP_SLTU: alu_1c = {{(XLEN-1){1'b0}}, (a_q < b_q)};
      OP_XOR:  alu_1c = a_q ^ b_q;
      OP_OR:   alu_1c = a_q | b_q;
      OP_AND:  alu_1c = a_q & b_q;
      OP_SLL, OP_SRL, OP_SRA: alu_1c = sh_out;
      default: alu_1c = '0;
    endcase
  end

  // ---------------- control FSM ----------------
  // pend_q marks a captured single-cycle request that completes on the next
  // edge; it runs alongside IDLE/DONE so a new request can be accepted in the
  // same cycle, giving one result per clock.
  always_comb begin
    state_n  = state_q;
    pend_n   = 1'b0;
    result_n = result_o;
    done_n   = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        state_n = pend_q ? DONE : IDLE;
        if (pend_q) begin
          result_n = alu_1c;
          done_n   = 1'b1;
        end
        if (accept) begin
          if (long_shift_in) begin
            state_n = SHIFT;
`ifdef ALU_SEQ_MUL_EN
          end else if (is_mul_in) begin
            state_n = MUL;
`endif
          end else begin
            pend_n = 1'b1;
          end
        end
      end
`ifdef ALU_SEQ_MUL_EN
      SHIFT, MUL: begin
`else
      SHIFT: begin
`endif
        if (sh_zero) begin
          result_n = sh_out;
          done_n   = 1'b1;
          state_n  = DONE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q  <= IDLE;
      pend_q   <= 1'b0;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      result_o <= '0;
      done_o   <= 1'b0;
    end else begin
      state_q  <= state_n;
      pend_q   <= pend_n;
      result_o <= result_n;
      done_o   <= done_n;
      if (accept) begin
        op_q <= op_i;
        a_q  <= a_i;
        b_q  <= b_i;
      end
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// ---------------------------------------------------------------------------
// tb_alu_seq
// Directed bench for alu_seq. Two instances share clock and reset:
//   dut  : XLEN=64, SHIFT_STEP=1
//   dut4 : XLEN=64, SHIFT_STEP=4
// Inputs are driven 1 time unit after a rising edge; outputs are sampled
// at the same point. Latency is the number of rising edges from the
// accepting edge to the edge after which done_o is seen high.
// ---------------------------------------------------------------------------
module tb_alu_seq;

  localparam logic [3:0] T_ADD = 4'd0, T_SUB = 4'd1, T_SLL = 4'd2,
                         T_SLT = 4'd3, T_SLTU = 4'd4, T_XOR = 4'd5,
                         T_SRL = 4'd6, T_SRA = 4'd7, T_OR = 4'd8,
                         T_AND = 4'd9, T_MUL = 4'd10;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid, valid4;
  logic [3:0]  op, op4;
  logic [63:0] a, b, a4, b4;
  logic        ready, ready4, done, done4;
  logic [63:0] result, result4;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_seq #(.XLEN(64), .SHIFT_STEP(1), .OPW(4)) dut (
    .clk_i(clk), .reset_i(rst_n), .valid_i(valid), .ready_o(ready),
    .op_i(op), .a_i(a), .b_i(b), .result_o(result), .done_o(done)
  );

  alu_seq #(.XLEN(64), .SHIFT_STEP(4), .OPW(4)) dut4 (
    .clk_i(clk), .reset_i(rst_n), .valid_i(valid4), .ready_o(ready4),
    .op_i(op4), .a_i(a4), .b_i(b4), .result_o(result4), .done_o(done4)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  function automatic logic obs_done(input bit u4);
    return u4 ? done4 : done;
  endfunction

  function automatic logic obs_ready(input bit u4);
    return u4 ? ready4 : ready;
  endfunction

  function automatic logic [63:0] obs_result(input bit u4);
    return u4 ? result4 : result;
  endfunction

  task automatic drive(input bit u4, input logic v, input logic [3:0] o,
                       input logic [63:0] x, input logic [63:0] y);
    if (u4) begin
      valid4 = v; op4 = o; a4 = x; b4 = y;
    end else begin
      valid = v; op = o; a = x; b = y;
    end
  endtask

  // One request; inputs are scrambled right after the accepting edge.
  task automatic run_op(input string name, input bit u4, input logic [3:0] o,
                        input logic [63:0] x, input logic [63:0] y,
                        input int exp_lat, input logic [63:0] exp_res);
    int lat;
    drive(u4, 1'b1, o, x, y);
    checks++;
    if (obs_ready(u4) !== 1'b1) begin
      errors++;
      $display("FAIL %s ready_before_accept: got %b expected 1", name, obs_ready(u4));
    end
    @(posedge clk); #1;
    drive(u4, 1'b0, ~o, ~x, y ^ 64'h5A5A_5A5A_5A5A_5A5A);
    lat = -1;
    for (int n = 0; n <= 300; n++) begin
      if (obs_done(u4) === 1'b1) begin
        lat = n;
        break;
      end
      @(posedge clk); #1;
    end
    checks++;
    if (lat != exp_lat) begin
      errors++;
      $display("FAIL %s latency: got %0d expected %0d (-1 = no done)", name, lat, exp_lat);
    end
    if (lat >= 0) begin
      checks++;
      if (obs_result(u4) !== exp_res) begin
        errors++;
        $display("FAIL %s result: got %h expected %h", name, obs_result(u4), exp_res);
      end
      @(posedge clk); #1;
      checks++;
      if (obs_done(u4) !== 1'b0 || obs_result(u4) !== exp_res) begin
        errors++;
        $display("FAIL %s pulse_hold: done %b result %h expected done 0 result %h",
                 name, obs_done(u4), obs_result(u4), exp_res);
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(1'b0, 1'b0, T_ADD, '0, '0);
    drive(1'b1, 1'b0, T_ADD, '0, '0);
    #3;
    checks++;
    if (ready !== 1'b1 || ready4 !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready: got %b/%b expected 1/1", ready, ready4);
    end
    checks++;
    if (done !== 1'b0 || done4 !== 1'b0) begin
      errors++;
      $display("FAIL reset_done: got %b/%b expected 0/0", done, done4);
    end
    checks++;
    if (result !== 64'd0 || result4 !== 64'd0) begin
      errors++;
      $display("FAIL reset_result: got %h/%h expected 0/0", result, result4);
    end
    #9 rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (ready !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_idle: ready %b done %b expected 1 0", ready, done);
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0]  ops [4] = '{T_ADD, T_SUB, T_SLT, T_SLTU};
    logic [63:0] as  [4] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF,
                             64'hFFFF_FFFF_FFFF_FFFF};
    logic [63:0] bs  [4] = '{64'd1, 64'd1, 64'd1, 64'd1};
    logic [63:0] exps[4] = '{64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0};
    drive(1'b0, 1'b1, ops[0], as[0], bs[0]);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if (i >= 1) begin
        checks++;
        if (done !== 1'b1 || result !== exps[i-1] || ready !== 1'b1) begin
          errors++;
          $display("FAIL b2b_%0d: done %b ready %b result %h expected 1 1 %h",
                   i - 1, done, ready, result, exps[i-1]);
        end
      end
      if (i < 3) drive(1'b0, 1'b1, ops[i+1], as[i+1], bs[i+1]);
      else drive(1'b0, 1'b0, T_ADD, 64'd7, 64'd7);
    end
    @(posedge clk); #1;
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL b2b_end: done %b expected 0", done);
    end
  endtask

  task automatic test_logic();
    run_op("xor", 1'b0, T_XOR, 64'hFF00, 64'h0FF0, 1, 64'hF0F0);
    run_op("or", 1'b0, T_OR, 64'hFF00, 64'h0FF0, 1, 64'hFFF0);
    run_op("slt_false", 1'b0, T_SLT, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 1, 64'd0);
    run_op("op11", 1'b0, 4'd11, 64'h1234, 64'h1, 1, 64'd0);
    run_op("srl_s4", 1'b0, T_SRL, 64'hF0, 64'd4, 4, 64'hF);
    run_op("and", 1'b0, T_AND, 64'hFF00, 64'h0FF0, 1, 64'h0F00);
  endtask

  task automatic test_sra_long();
    int lat;
    int ready_hi;
    drive(1'b0, 1'b1, T_SRA, 64'h8000_0000_0000_0000, 64'd63);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, T_ADD, 64'd0, 64'd0);
    lat = -1;
    ready_hi = 0;
    for (int n = 0; n <= 200; n++) begin
      if (done === 1'b1) begin
        lat = n;
        break;
      end
      if (ready !== 1'b0) ready_hi++;
      if (n == 10) drive(1'b0, 1'b1, T_ADD, 64'd1, 64'd1);
      if (n == 11) drive(1'b0, 1'b0, T_ADD, 64'd1, 64'd1);
      @(posedge clk); #1;
    end
    checks++;
    if (lat != 63) begin
      errors++;
      $display("FAIL sra63_latency: got %0d expected 63", lat);
    end
    checks++;
    if (result !== 64'hFFFF_FFFF_FFFF_FFFF) begin
      errors++;
      $display("FAIL sra63_result: got %h expected ffffffffffffffff", result);
    end
    checks++;
    if (ready_hi != 0) begin
      errors++;
      $display("FAIL sra63_busy_ready: ready high in %0d busy cycles, expected 0", ready_hi);
    end
    checks++;
    if (ready !== 1'b1) begin
      errors++;
      $display("FAIL sra63_ready_at_done: got %b expected 1", ready);
    end
    lat = 0;
    repeat (4) begin
      @(posedge clk); #1;
      if (done === 1'b1) lat++;
    end
    checks++;
    if (lat != 0 || result !== 64'hFFFF_FFFF_FFFF_FFFF) begin
      errors++;
      $display("FAIL sra63_ignored_req: %0d extra done, result %h expected 0 and ffffffffffffffff",
               lat, result);
    end
  endtask

  task automatic test_step4();
    run_op("sll13_step4", 1'b1, T_SLL, 64'd1, 64'd13, 4, 64'h2000);
    run_op("srl0_step4", 1'b1, T_SRL, 64'hF0, 64'd0, 1, 64'hF0);
    run_op("srl4_step4", 1'b1, T_SRL, 64'hF0, 64'd4, 1, 64'hF);
    run_op("sra5_step4", 1'b1, T_SRA, 64'h8000_0000_0000_0000, 64'd5, 2,
           64'hFC00_0000_0000_0000);
  endtask

  task automatic test_undef();
    run_op("undef12", 1'b0, 4'd12, 64'h55, 64'h55, 1, 64'd0);
    run_op("add_inputs_changed", 1'b0, T_ADD, 64'd3, 64'd4, 1, 64'd7);
  endtask

  task automatic test_reset_mid_shift();
    int seen;
    drive(1'b0, 1'b1, T_SLL, 64'd1, 64'd40);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, T_ADD, 64'd0, 64'd0);
    repeat (5) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (ready !== 1'b1 || done !== 1'b0 || result !== 64'd0) begin
      errors++;
      $display("FAIL midreset_state: ready %b done %b result %h expected 1 0 0",
               ready, done, result);
    end
    @(posedge clk);
    #2 rst_n = 1'b1;
    seen = 0;
    repeat (60) begin
      @(posedge clk); #1;
      if (done === 1'b1) seen++;
    end
    checks++;
    if (seen != 0 || result !== 64'd0 || ready !== 1'b1) begin
      errors++;
      $display("FAIL midreset_abort: %0d done pulses, result %h ready %b expected 0 0 1",
               seen, result, ready);
    end
    run_op("add_after_reset", 1'b0, T_ADD, 64'd2, 64'd3, 1, 64'd5);
  endtask

  task automatic test_mul();
`ifdef ALU_SEQ_MUL_EN
    run_op("mul", 1'b0, T_MUL, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 64, 64'hFFFF_FFFE_0000_0001);
`else
    run_op("mul_absent", 1'b0, T_MUL, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 1, 64'd0);
`endif
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_logic();
    test_sra_long();
    test_step4();
    test_undef();
    test_reset_mid_shift();
    test_mul();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, multi-cycle successor of the single-cycle ALU for the Polaris integer pipeline.
- Performs RV64I-style integer operations behind a valid/ready request and done-pulse response.
- Logic and add ops complete in 1 cycle. Shifts iterate SHIFT_STEP bits per cycle, trading area for latency.
- Sits between the decode/register-read stage and writeback; the pipeline stalls while ready_o is low.

Parameters:
- XLEN, 64, datapath width in bits; power of 2, 8..64.
- SHIFT_STEP, 1, bits shifted per cycle; power of 2, 1..XLEN.
- OPW, 4, opcode width.

Ports:
- clk_i  in  1  clock; all state changes on its rising edge.
- reset_i  in  1  asynchronous, active-low reset.
- valid_i  in  1  request valid.
- ready_o  out  1  block idle and able to accept a request.
- op_i  in  OPW  operation code.
- a_i  in  XLEN  operand A.
- b_i  in  XLEN  operand B; bits [log2(XLEN)-1:0] are the shift amount for shifts.
- result_o  out  XLEN  result; held stable until the next done_o.
- done_o  out  1  one-cycle pulse; result_o is valid in this cycle.

Behaviour:
- Reset (reset_i low, asynchronous): state IDLE, ready_o=1, done_o=0, result_o=0, internal accumulator and counter cleared.
- Reset asserted mid-operation aborts the operation with no done_o and no result update.
- Accept: a request is taken on a rising edge with valid_i=1 and ready_o=1.
  - op_i, a_i and b_i are captured on that edge.
  - Later changes to the inputs are ignored until the next accept.
  - valid_i while ready_o=0 is ignored; the requester must hold it.
- Latency L is counted from the accepting edge; done_o is high for exactly the cycle following edge k+L.
- Opcodes and results:
  - 0 ADD: a+b, mod 2^XLEN. L=1.
  - 1 SUB: a-b, mod 2^XLEN. L=1.
  - 2 SLL, 6 SRL, 7 SRA: shift amount s = b[log2(XLEN)-1:0]. L = max(1, ceil(s/SHIFT_STEP)). Each cycle shifts by min(SHIFT_STEP, remaining). SRA replicates a[XLEN-1].
  - 3 SLT: signed a<b gives 1, else 0. L=1.
  - 4 SLTU: unsigned a<b gives 1, else 0. L=1.
  - 5 XOR, 8 OR, 9 AND: bitwise. L=1.
  - 10 MUL: optional feature, see below.
  - 11..15, and 10 when MUL is not built: result 0, L=1.
- FSM states:
  - IDLE: ready_o=1. On accept go to DONE if L=1, else SHIFT or MUL.
  - SHIFT: ready_o=0. Decrement the remaining count each cycle; go to DONE when it reaches 0.
  - MUL: ready_o=0. Run XLEN iterations, then go to DONE.
  - DONE: the transition into DONE registers result_o and asserts done_o. DONE behaves as IDLE (ready_o=1), so a new request may be accepted in the same cycle done_o is high. The back-to-back throughput for 1-cycle ops is one result per clock.
- s=0 shift returns a unchanged with L=1.
- s=XLEN-1 with SHIFT_STEP=1 gives L=XLEN-1.

Optional Feature:
- Macro: ALU_SEQ_MUL_EN.
- Defined: opcode 10 MUL returns the low XLEN bits of a*b using a radix-2 shift-add over the shared accumulator. L=XLEN, independent of operand values. Signed and unsigned give the same low half.
- Undefined: opcode 10 yields result 0 with L=1. No multiplier logic and no MUL state is built.

Decomposition:
- Package alu_seq_pkg holds:
  - opcode localparams OP_ADD..OP_MUL;
  - FSM state encoding IDLE/SHIFT/MUL/DONE;
  - function clog2 for the shift-amount and counter widths.
- One sub-module, alu_seq_shifter: the sequential shift datapath.
  - Holds the accumulator, the remaining-count register and the left/right/arith mode.
  - Has load and step controls and a zero flag.
  - The top-level FSM and the single-cycle ops stay in alu_seq.

Test Plan:
1. Reset low mid-SHIFT (SLL, s=40, after 5 cycles), then release: ready_o=1, done_o never pulses, result_o=0. A following ADD 2+3 gives result_o=5 with L=1.
2. Back-to-back, valid_i held high: ADD 0xFFFFFFFFFFFFFFFF+1, SUB 0-1, SLT -1<1, SLTU -1<1. Results 0, 0xFFFFFFFFFFFFFFFF, 1, 0, on four consecutive done_o cycles.
3. SRA a=0x8000000000000000, s=63, SHIFT_STEP=1: done_o 63 edges after accept, result 0xFFFFFFFFFFFFFFFF. ready_o is low throughout, and a valid_i pulse during busy is ignored.
4. SLL a=1, s=13, SHIFT_STEP=4: L=4, result 0x2000. SRL a=0xF0, s=0: L=1, result 0xF0.
5. Undefined op 12, a=b=0x55: result 0, L=1. Inputs changed the cycle after accept do not affect the result.
6. With ALU_SEQ_MUL_EN, MUL 0xFFFFFFFF*0xFFFFFFFF: done_o at L=64, result 0xFFFFFFFE00000001. Without the macro, the same op gives result 0 with L=1.
